// File: rtl/shift_pkg.sv
// Shared types for the shift arbiter slice: shift operation encoding and the
// response-register state.
package shift_pkg;

   typedef enum logic [1:0] {
      SHIFT_SLL  = 2'd0,
      SHIFT_SRL  = 2'd1,
      SHIFT_SRA  = 2'd2,
      SHIFT_PASS = 2'd3
   } shift_op_t;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_FULL = 1'b1
   } arb_state_t;

endpackage

// File: rtl/shift_core.sv
// Combinational shifter: sll, srl and sra results muxed by op.
// A zero shift amount returns the operand unchanged for every op.
module shift_core
   import shift_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  shift_op_t              op,
   input  logic [N-1:0]           in_data,
   input  logic [$clog2(N)-1:0]   shamt,
   output logic [N-1:0]           out_data
);

   logic [N-1:0] sll_res;
   logic [N-1:0] srl_res;
   logic [N-1:0] sra_res;

   always_comb begin
      sll_res = in_data << shamt;
      srl_res = in_data >> shamt;
      sra_res = $unsigned($signed(in_data) >>> shamt);
   end

   always_comb begin
      out_data = in_data;
      case (op)
         SHIFT_SLL:  out_data = sll_res;
         SHIFT_SRL:  out_data = srl_res;
         SHIFT_SRA:  out_data = sra_res;
         SHIFT_PASS: out_data = in_data;
         default:    out_data = in_data;
      endcase
   end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core between two valid/ready requesters.
// Define SHIFT_ARB_STATS_EN to add per-requester accepted-request counters.
module shift_arbiter
   import shift_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [1:0]             req0_op,
   input  logic [N-1:0]           req0_in,
   input  logic [$clog2(N)-1:0]   req0_shamt,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [1:0]             req1_op,
   input  logic [N-1:0]           req1_in,
   input  logic [$clog2(N)-1:0]   req1_shamt,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic                   resp_id,
`ifdef SHIFT_ARB_STATS_EN
   output logic [31:0]            grant_count0,
   output logic [31:0]            grant_count1,
`endif
   output logic [N-1:0]           resp_out
);

   arb_state_t             state_q, state_d;
   logic                   rr_ptr_q, rr_ptr_d;
   logic                   resp_id_q, resp_id_d;
   logic [N-1:0]           resp_out_q, resp_out_d;

   logic                   can_accept;
   logic                   gnt0, gnt1;
   logic                   accept;
   shift_op_t              sel_op;
   logic [N-1:0]           sel_in;
   logic [$clog2(N)-1:0]   sel_shamt;
   logic [N-1:0]           core_out;

   // Grant depends only on the valids and rr_ptr; the payload mux follows gnt1.
   always_comb begin
      can_accept = !rst && ((state_q == ARB_IDLE) || resp_ready);
      gnt0       = req0_valid && (!req1_valid || !rr_ptr_q);
      gnt1       = req1_valid && (!req0_valid ||  rr_ptr_q);
      req0_ready = can_accept && gnt0;
      req1_ready = can_accept && gnt1;
      accept     = req0_ready || req1_ready;
      sel_op     = gnt1 ? shift_op_t'(req1_op) : shift_op_t'(req0_op);
      sel_in     = gnt1 ? req1_in    : req0_in;
      sel_shamt  = gnt1 ? req1_shamt : req0_shamt;
   end

   shift_core #(.N(N)) u_core (
      .op       (sel_op),
      .in_data  (sel_in),
      .shamt    (sel_shamt),
      .out_data (core_out)
   );

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      resp_id_d  = resp_id_q;
      resp_out_d = resp_out_q;
      if (accept) begin
         state_d    = ARB_FULL;
         resp_out_d = core_out;
         resp_id_d  = req1_ready;
         rr_ptr_d   = !req1_ready;
      end else if ((state_q == ARB_FULL) && resp_ready) begin
         state_d = ARB_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         rr_ptr_q   <= 1'b0;
         resp_id_q  <= 1'b0;
         resp_out_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         resp_id_q  <= resp_id_d;
         resp_out_q <= resp_out_d;
      end
   end

   assign resp_valid = (state_q == ARB_FULL);
   assign resp_id    = resp_id_q;
   assign resp_out   = resp_out_q;

`ifdef SHIFT_ARB_STATS_EN
   logic [31:0] cnt0_q, cnt0_d;
   logic [31:0] cnt1_q, cnt1_d;

   always_comb begin
      cnt0_d = cnt0_q + {31'b0, req0_ready};
      cnt1_d = cnt1_q + {31'b0, req1_ready};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign grant_count0 = cnt0_q;
   assign grant_count1 = cnt1_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized self-checking bench for shift_arbiter against a behavioural model.
// Counter checks are active when SHIFT_ARB_STATS_EN is defined.
module tb_shift_arbiter;
   import shift_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [1:0]  req0_op, req1_op;
   logic [31:0] req0_in, req1_in;
   logic [4:0]  req0_shamt, req1_shamt;
   logic        resp_valid, resp_ready, resp_id;
   logic [31:0] resp_out;
`ifdef SHIFT_ARB_STATS_EN
   logic [31:0] grant_count0, grant_count1;
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference model state
   bit          m_full;
   bit          m_id;
   logic [31:0] m_out;
   bit          m_rr;
   logic [31:0] m_cnt0, m_cnt1;

   always #5 clk = ~clk;

   shift_arbiter #(.N(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_op      (req0_op),
      .req0_in      (req0_in),
      .req0_shamt   (req0_shamt),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_op      (req1_op),
      .req1_in      (req1_in),
      .req1_shamt   (req1_shamt),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_id      (resp_id),
`ifdef SHIFT_ARB_STATS_EN
      .grant_count0 (grant_count0),
      .grant_count1 (grant_count1),
`endif
      .resp_out     (resp_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Shift semantics expressed as arithmetic on powers of two.
   function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] x,
                                             input logic [4:0] sh);
      logic [63:0] p;
      logic [31:0] d;
      d = 32'd1 << sh;
      case (op)
         2'd0: begin
            p = {32'b0, x} * {32'b0, d};
            return p[31:0];
         end
         2'd1: return x / d;
         2'd2: return x[31] ? ~((~x) / d) : x / d;
         default: return x;
      endcase
   endfunction

   // One clock: check readys before the edge, advance the model, check outputs after.
   task automatic step(output bit a0, output bit a1);
      bit can;
      #1;
      can = !rst && (!m_full || resp_ready);
      a0  = can && req0_valid && (!req1_valid || !m_rr);
      a1  = can && req1_valid && (!req0_valid ||  m_rr);
      check("req0_ready", 32'(req0_ready), 32'(a0));
      check("req1_ready", 32'(req1_ready), 32'(a1));
      @(posedge clk);
      if (rst) begin
         m_full = 0; m_id = 0; m_out = '0; m_rr = 0; m_cnt0 = '0; m_cnt1 = '0;
      end else if (a0 || a1) begin
         m_full = 1;
         m_id   = a1;
         m_out  = a1 ? ref_shift(req1_op, req1_in, req1_shamt)
                     : ref_shift(req0_op, req0_in, req0_shamt);
         m_rr   = a0;
         if (a0) m_cnt0 = m_cnt0 + 32'd1;
         if (a1) m_cnt1 = m_cnt1 + 32'd1;
      end else if (m_full && resp_ready) begin
         m_full = 0;
      end
      #1;
      check("resp_valid", 32'(resp_valid), 32'(m_full));
      if (m_full) begin
         check("resp_id", 32'(resp_id), 32'(m_id));
         check("resp_out", resp_out, m_out);
      end
`ifdef SHIFT_ARB_STATS_EN
      check("grant_count0", grant_count0, m_cnt0);
      check("grant_count1", grant_count1, m_cnt1);
`endif
   endtask

   task automatic drive0(input bit v, input logic [1:0] op, input logic [31:0] x,
                         input logic [4:0] sh);
      req0_valid = v; req0_op = op; req0_in = x; req0_shamt = sh;
   endtask

   task automatic drive1(input bit v, input logic [1:0] op, input logic [31:0] x,
                         input logic [4:0] sh);
      req1_valid = v; req1_op = op; req1_in = x; req1_shamt = sh;
   endtask

   function automatic logic [4:0] rand_shamt();
      case ($urandom_range(0, 3))
         0: return 5'd0;
         1: return 5'd31;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   initial begin
      bit a0, a1;
      logic [31:0] exp_out;
      rst = 1'b1; resp_ready = 1'b1;
      drive0(1, 2'd0, 32'h1234_5678, 5'd3);
      drive1(1, 2'd1, 32'h8765_4321, 5'd5);
      m_full = 0; m_id = 0; m_out = '0; m_rr = 0; m_cnt0 = '0; m_cnt1 = '0;
      @(posedge clk); #1;

      // Reset with both requesters valid
      step(a0, a1);
      step(a0, a1);
      check("rst_resp_out", resp_out, 32'h0);
      check("rst_resp_id", 32'(resp_id), 32'h0);
      rst = 1'b0;
      step(a0, a1);
      check("first_grant_req0", 32'(a0), 32'h1);

      // Single SRA op
      drive0(1, 2'd2, 32'h8000_00F0, 5'd4);
      drive1(0, 2'd0, '0, '0);
      step(a0, a1);
      check("sra_out", resp_out, 32'hF800_000F);
      check("sra_id", 32'(resp_id), 32'h0);

      // Move priority back to req0, then alternate
      drive0(0, 2'd0, '0, '0);
      drive1(1, 2'd3, 32'hDEAD_BEEF, 5'd0);
      step(a0, a1);
      drive0(1, 2'd0, 32'h0000_0001, 5'd31);
      drive1(1, 2'd1, 32'hFFFF_FFFF, 5'd31);
      for (int i = 0; i < 4; i++) begin
         step(a0, a1);
         check("fair_id", 32'(resp_id), 32'(i % 2));
         check("fair_out", resp_out, (i % 2 == 0) ? 32'h8000_0000 : 32'h0000_0001);
      end

      // Backpressure: last result was id1, out 1
      resp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(a0, a1);
         check("bp_out_stable", resp_out, 32'h0000_0001);
         check("bp_id_stable", 32'(resp_id), 32'h1);
         check("bp_no_grant", 32'(a0 | a1), 32'h0);
      end
      resp_ready = 1'b1;
      step(a0, a1);
      check("bp_release_grant0", 32'(a0), 32'h1);
      check("bp_release_valid", 32'(resp_valid), 32'h1);

      // Zero shift amount and PASS boundaries
      drive1(0, 2'd0, '0, '0);
      for (int op = 0; op < 4; op++) begin
         drive0(1, 2'(op), 32'hA5A5_A5A5, 5'd0);
         step(a0, a1);
         check("shamt0_out", resp_out, 32'hA5A5_A5A5);
      end
      drive0(1, 2'd3, 32'h1357_9BDF, 5'd7);
      step(a0, a1);
      check("pass_shamt7", resp_out, 32'h1357_9BDF);

      // Mid-operation reset drops the held result
      drive0(1, 2'd0, 32'h0000_00FF, 5'd8);
      step(a0, a1);
      drive0(0, 2'd0, '0, '0);
      resp_ready = 1'b0;
      rst = 1'b1;
      step(a0, a1);
      check("midrst_valid", 32'(resp_valid), 32'h0);
      rst = 1'b0;
      resp_ready = 1'b1;
      step(a0, a1);
      check("midrst_not_delivered", 32'(resp_valid), 32'h0);

      // Grant counters: 5 from req0, 3 from req1
      for (int i = 0; i < 8; i++) begin
         drive0(i < 5, 2'd1, 32'(i), 5'd1);
         drive1(i >= 5, 2'd0, 32'(i), 5'd1);
         step(a0, a1);
      end
      drive0(0, 2'd0, '0, '0);
      drive1(0, 2'd0, '0, '0);
`ifdef SHIFT_ARB_STATS_EN
      check("stats_cnt0", grant_count0, 32'd5);
      check("stats_cnt1", grant_count1, 32'd3);
      rst = 1'b1;
      step(a0, a1);
      rst = 1'b0;
      check("stats_cnt0_rst", grant_count0, 32'd0);
      check("stats_cnt1_rst", grant_count1, 32'd0);
`endif

      // Randomized traffic; requesters hold payload until accepted
      a0 = 1; a1 = 1;
      for (int i = 0; i < 400; i++) begin
         if (a0 || !req0_valid)
            drive0($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), $urandom, rand_shamt());
         if (a1 || !req1_valid)
            drive1($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), $urandom, rand_shamt());
         resp_ready = $urandom_range(0, 3) != 0;
         rst = $urandom_range(0, 59) == 0;
         step(a0, a1);
         if (rst) begin a0 = 1; a1 = 1; end
      end
      rst = 1'b0;

      // Spot-check the model's shift arithmetic against fixed values
      exp_out = ref_shift(2'd2, 32'h8000_0000, 5'd31);
      check("model_sra31", exp_out, 32'hFFFF_FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
